// File: rtl/spi_master_p.sv
// rtl/spi_master_p.sv - parametrised SPI master with per-transfer length, divider, mode and slave select.
// Optional SPI_BYTESWAP_EN: multi-byte transfers go on the wire least-significant byte first.
module spi_master_p #(
  parameter int DW   = 32,
  parameter int DIVW = 8,
  parameter int NCS  = 4,
  localparam int NBW = (DW / 8 > 1) ? $clog2(DW / 8) : 1,
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DIVW-1:0] div,
  input  logic [NBW-1:0]  nbytes,
  input  logic            cpol,
  input  logic            cpha,
  input  logic [CSW-1:0]  cs_sel,
  input  logic            cs_hold,
  input  logic            csrel,
  input  logic [DW-1:0]   dataTx,
  output logic [DW-1:0]   dataRx,
  output logic            rdy,
  input  logic            MISO,
  output logic            MOSI,
  output logic            SCLK,
  output logic [NCS-1:0]  SS_n
);

  localparam int BW = $clog2(DW) + 1;
  localparam logic [BW:0] ONE_H = {{BW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t          state, state_n;
  logic [DIVW-1:0] div_q, cnt;
  logic [NBW-1:0]  nb_q;
  logic [BW:0]     hcnt;
  logic            cpol_q, cpha_q, hold_q;
  logic [DW-1:0]   txsr, rxsr;
  logic            sclk_q, mosi_q;
  logic [NCS-1:0]  ss_q;
  logic            tick, hlast, accept, lead_evt, trail_evt, sample, advance;
  logic [BW-1:0]   nbits, nbits_in;
  logic [DW-1:0]   tx_in, tx_al;

`ifdef SPI_BYTESWAP_EN
  // Reverses byte order within the low nb+1 bytes; its own inverse.
  function automatic logic [DW-1:0] bswap(input logic [DW-1:0] x, input logic [NBW-1:0] nb);
    logic [DW-1:0] y;
    y = '0;
    for (int k = 0; k < DW / 8; k++)
      if (k <= int'(nb)) y[8*k +: 8] = x[8*(int'(nb) - k) +: 8];
    return y;
  endfunction
  assign tx_in  = bswap(dataTx, nbytes);
  assign dataRx = bswap(rxsr, nb_q);
`else
  assign tx_in  = dataTx;
  assign dataRx = rxsr;
`endif

  // Transmit word is left-aligned so the bit on the wire is always txsr[DW-1].
  assign nbits_in = BW'({nbytes, 3'b000}) + BW'(8);
  assign tx_al    = tx_in << (BW'(DW) - nbits_in);
  assign nbits    = BW'({nb_q, 3'b000}) + BW'(8);

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    lead_evt  = 1'b0;
    trail_evt = 1'b0;
    tick      = (cnt == div_q);
    hlast     = (hcnt == ({nbits, 1'b0} - ONE_H));
    case (state)
      IDLE:  if (start) begin
               accept  = 1'b1;
               state_n = LEAD;
             end
      LEAD:  if (tick) begin
               lead_evt = 1'b1;
               state_n  = SHIFT;
             end
      // Half-period h ends: entering an odd one is a trailing edge, an even one a leading edge.
      SHIFT: if (tick) begin
               if (hlast)        state_n   = TRAIL;
               else if (hcnt[0]) lead_evt  = 1'b1;
               else              trail_evt = 1'b1;
             end
      TRAIL: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    sample  = cpha_q ? trail_evt : lead_evt;
    advance = cpha_q ? lead_evt  : trail_evt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hcnt   <= '0;
      div_q  <= '0;
      nb_q   <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      hold_q <= 1'b0;
      txsr   <= '0;
      rxsr   <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b1;
      ss_q   <= '1;
    end else begin
      state <= state_n;
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + DIVW'(1);
      if (accept) begin
        div_q  <= div;
        nb_q   <= nbytes;
        cpol_q <= cpol;
        cpha_q <= cpha;
        hold_q <= cs_hold;
        hcnt   <= '0;
        rxsr   <= '0;
        sclk_q <= cpol;
        ss_q   <= ~(NCS'(1) << cs_sel);
        if (cpha) begin
          mosi_q <= 1'b1;
          txsr   <= tx_al;
        end else begin
          mosi_q <= tx_al[DW-1];
          txsr   <= {tx_al[DW-2:0], 1'b0};
        end
      end else begin
        if (state == IDLE && csrel) ss_q <= '1;
        if (state == SHIFT && tick) hcnt <= hcnt + ONE_H;
        if (lead_evt)  sclk_q <= ~cpol_q;
        if (trail_evt) sclk_q <= cpol_q;
        if (sample) rxsr <= {rxsr[DW-2:0], MISO};
        if (advance) begin
          mosi_q <= txsr[DW-1];
          txsr   <= {txsr[DW-2:0], 1'b0};
        end
        if (state == TRAIL && tick) begin
          mosi_q <= 1'b1;
          if (!hold_q) ss_q <= '1;
        end
      end
    end
  end

  assign rdy  = (state == IDLE);
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign SS_n = ss_q;

endmodule

// File: tb/tb_spi_master_p.sv
// tb/tb_spi_master_p.sv - directed bench for spi_master_p with a simple SPI slave model.
module tb_spi_master_p;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  div = '0;
  logic [1:0]  nbytes = '0;
  logic        cpol = 1'b0, cpha = 1'b0;
  logic [1:0]  cs_sel = '0;
  logic        cs_hold = 1'b0, csrel = 1'b0;
  logic [31:0] dataTx = '0;
  logic [31:0] dataRx;
  logic        rdy, MISO, MOSI, SCLK;
  logic [3:0]  SS_n;

  logic        loop = 1'b0, t_cpol = 1'b0, t_cpha = 1'b0;
  logic [7:0]  slv_data = '0, slv_sh = '0;
  logic        slv_miso = 1'b1;
  logic [31:0] slv_rx = '0;
  int          rises = 0;
  logic        mon_ss1 = 1'b0, ss1_broke = 1'b0;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b1;
  logic [3:0]  prev_ssn = 4'hF;

  int total = 0, passed = 0, nfail = 0;
  int k;

  assign MISO = loop ? MOSI : slv_miso;

  spi_master_p dut (
    .clk(clk), .rst(rst), .start(start), .div(div), .nbytes(nbytes),
    .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel), .cs_hold(cs_hold), .csrel(csrel),
    .dataTx(dataTx), .dataRx(dataRx), .rdy(rdy), .MISO(MISO), .MOSI(MOSI),
    .SCLK(SCLK), .SS_n(SS_n)
  );

  always #5 clk = ~clk;

  // Slave sees values from just before each clk edge, like a real device sampling on SCLK.
  always @(negedge clk) begin
    if (prev_ssn != 4'hF && SCLK !== prev_sclk) begin
      if (SCLK && !prev_sclk) rises = rises + 1;
      if ((SCLK != t_cpol) ^ t_cpha) slv_rx = {slv_rx[30:0], prev_mosi};
      else begin
        slv_miso = slv_sh[7];
        slv_sh   = {slv_sh[6:0], 1'b0};
      end
    end
    if (prev_ssn == 4'hF && SS_n != 4'hF) begin
      slv_rx = '0;
      rises  = 0;
      if (t_cpha) begin slv_miso = 1'b1; slv_sh = slv_data; end
      else begin slv_miso = slv_data[7]; slv_sh = {slv_data[6:0], 1'b0}; end
    end
    if (!mon_ss1) ss1_broke = 1'b0;
    else if (SS_n[1]) ss1_broke = 1'b1;
    prev_sclk = SCLK;
    prev_mosi = MOSI;
    prev_ssn  = SS_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go(input logic [7:0] d, input logic [1:0] nb, input logic cp, input logic ch,
                    input logic [1:0] cs, input logic hold, input logic [31:0] tx);
    div = d; nbytes = nb; cpol = cp; cpha = ch; cs_sel = cs; cs_hold = hold; dataTx = tx;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_wait(input int k0, output int kk);
    kk = k0;
    while (rdy !== 1'b1 && kk < 3000) begin @(posedge clk); #1; kk++; end
  endtask

  initial begin
    step(3);
    rst = 1'b1;
    step(10);
    chk("reset_rdy", rdy, 1);
    chk("reset_ssn", SS_n, 4'b1111);
    chk("reset_sclk", SCLK, 0);
    chk("reset_mosi", MOSI, 1);
    chk("reset_datarx", dataRx, 0);

    loop = 1'b1;
    go(8'd0, 2'd3, 1'b0, 1'b0, 2'd2, 1'b0, 32'hA5C3_0F81);
    chk("lb_ssn_active", SS_n, 4'b1011);
    chk("lb_rdy_low", rdy, 0);
    run_wait(0, k);
    chk("lb_latency", k + 1, 67);
    chk("lb_datarx", dataRx, 32'hA5C3_0F81);
    chk("lb_ssn_after", SS_n, 4'b1111);
    chk("lb_rises", rises, 32);
    chk("lb_mosi_idle", MOSI, 1);

    loop = 1'b0; t_cpol = 1'b1; t_cpha = 1'b1; slv_data = 8'h96;
    go(8'd3, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_003C);
    chk("md_sclk_lead", SCLK, 1);
    step(3);
    chk("md_sclk_e3", SCLK, 1);
    step(1);
    chk("md_sclk_e4", SCLK, 0);
    step(4);
    chk("md_sclk_e8", SCLK, 1);
    run_wait(8, k);
    chk("md_latency", k + 1, 73);
    chk("md_datarx", dataRx, 32'h0000_0096);
    chk("md_slave_rx", slv_rx, 32'h0000_003C);
    chk("md_sclk_idle", SCLK, 1);

    loop = 1'b1; t_cpol = 1'b0; t_cpha = 1'b0;
    go(8'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_005A);
    mon_ss1 = 1'b1;
    run_wait(0, k);
    chk("hold_lat1", k + 1, 19);
    chk("hold_ssn_idle", SS_n, 4'b1101);
    go(8'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_00C3);
    chk("hold_restart", rdy, 0);
    run_wait(0, k);
    chk("hold_lat2", k + 1, 19);
    chk("hold_datarx", dataRx, 32'h0000_00C3);
    step(1);
    chk("hold_ss1_cont", ss1_broke, 0);
    mon_ss1 = 1'b0;
    chk("hold_ssn_held", SS_n, 4'b1101);
    csrel = 1'b1;
    step(1);
    csrel = 1'b0;
    chk("csrel_release", SS_n, 4'b1111);
    go(8'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0000_0077);
    run_wait(0, k);
    chk("hold_again", SS_n, 4'b1101);
    csrel = 1'b1;
    go(8'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0000_00E1);
    csrel = 1'b0;
    chk("switch_cs", SS_n, 4'b0111);
    run_wait(0, k);
    chk("switch_datarx", dataRx, 32'h0000_00E1);
    chk("switch_release", SS_n, 4'b1111);

    go(8'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_BEEF);
    step(20);
    cs_sel = 2'd2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("busy_start_rdy", rdy, 0);
    chk("busy_start_ssn", SS_n, 4'b1110);
    rst = 1'b0;
    step(1);
    chk("abort_rdy", rdy, 1);
    chk("abort_ssn", SS_n, 4'b1111);
    chk("abort_sclk", SCLK, 0);
    chk("abort_mosi", MOSI, 1);
    chk("abort_datarx", dataRx, 0);
    rst = 1'b1;
    step(2);

    go(8'd0, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 32'h1122_3344);
    run_wait(0, k);
    chk("bs_latency", k + 1, 67);
    chk("bs_datarx", dataRx, 32'h1122_3344);
`ifdef SPI_BYTESWAP_EN
    chk("bs_wire", slv_rx, 32'h4433_2211);
`else
    chk("bs_wire", slv_rx, 32'h1122_3344);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
